// File: rtl/gf251_pkg.sv
// Shared GF(251) constants, beat control types and modular reduction helpers.
// Lane datapaths and the handshake top both import this package.
package gf251_pkg;

    localparam int unsigned Q = 251;

    typedef enum logic {
        ModeMul = 1'b0,
        ModeMac = 1'b1
    } mode_e;

    typedef struct packed {
        mode_e mode;
        logic  clr;
    } beat_ctrl_t;

    // Bytes 0xFB..0xFF fold down to 0..4.
    function automatic logic [7:0] reduce8(input logic [7:0] x);
        return (x >= 8'(Q)) ? x - 8'(Q) : x;
    endfunction

    // 256 = 5 (mod 251), so fold the high byte twice and finish with one conditional subtract.
    function automatic logic [7:0] reduce16(input logic [15:0] x);
        logic [10:0] t1;
        logic [8:0]  t2;
        t1 = 11'(x[15:8]) * 11'd5 + 11'(x[7:0]);
        t2 = 9'(t1[10:8]) * 9'd5 + 9'(t1[7:0]);
        if (t2 >= 9'(Q)) begin
            t2 = t2 - 9'(Q);
        end
        return t2[7:0];
    endfunction

    function automatic logic [7:0] add_mod(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = 9'(a) + 9'(b);
        if (s >= 9'(Q)) begin
            s = s - 9'(Q);
        end
        return s[7:0];
    endfunction

endpackage

// File: rtl/gf251_lane.sv
// One 8-bit GF(251) lane: operand reduce, raw product, reduce/accumulate.
// Control (valid, mode, clear, stall) comes from the shared handshake in the top.
module gf251_lane
    import gf251_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_stall,
    input  logic [7:0] i_x,
    input  logic [7:0] i_y,
    input  logic       i_s2_valid,
    input  logic       i_s2_mac,
    input  logic       i_s2_clr,
    output logic [7:0] o_res
);

    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] prod_q, prod_d;
    logic [7:0]  res_q, res_d;
    logic [7:0]  acc_q, acc_d;
    logic [7:0]  prod_red;
    logic [7:0]  acc_next;

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        prod_d   = prod_q;
        res_d    = res_q;
        acc_d    = acc_q;
        prod_red = reduce16(prod_q);
        acc_next = i_s2_clr ? prod_red : add_mod(acc_q, prod_red);
        if (!i_stall) begin
            a_d    = reduce8(i_x);
            b_d    = reduce8(i_y);
            prod_d = 16'(a_q) * 16'(b_q);
            // Result and accumulator only move when a real beat crosses S2 -> S3.
            if (i_s2_valid) begin
                if (i_s2_mac) begin
                    acc_d = acc_next;
                    res_d = acc_next;
                end else begin
                    res_d = prod_red;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            res_q  <= '0;
            acc_q  <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            prod_q <= prod_d;
            res_q  <= res_d;
            acc_q  <= acc_d;
        end
    end

    assign o_res = res_q;

endmodule

// File: rtl/gf251_mul_vec.sv
// Vector GF(251) multiply / multiply-accumulate, 3-stage pipe with valid/ready.
// Stage valids and per-beat mode/clear live here; data lives in the lanes.
module gf251_mul_vec
    import gf251_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned W     = 8 * LANES
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    input  logic         i_mode,
    input  logic         i_acc_clr,
    input  logic         i_start,
    output logic         o_ready,
    output logic [W-1:0] o_o,
    output logic         o_done,
    input  logic         i_ready
);

    logic       stall;
    logic       accept;
    logic       v1_q, v1_d;
    logic       v2_q, v2_d;
    logic       v3_q, v3_d;
    beat_ctrl_t ctrl1_q, ctrl1_d;
    beat_ctrl_t ctrl2_q, ctrl2_d;

    always_comb begin
        stall   = v3_q & ~i_ready;
        accept  = i_start & ~stall;
        v1_d    = v1_q;
        v2_d    = v2_q;
        v3_d    = v3_q;
        ctrl1_d = ctrl1_q;
        ctrl2_d = ctrl2_q;
        if (!stall) begin
            v1_d         = accept;
            ctrl1_d.mode = mode_e'(i_mode);
            // Clear has no meaning for a multiply beat, so drop it at the door.
            ctrl1_d.clr  = i_acc_clr & i_mode;
            v2_d         = v1_q;
            ctrl2_d      = ctrl1_q;
            v3_d         = v2_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            ctrl1_q <= '0;
            ctrl2_q <= '0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            ctrl1_q <= ctrl1_d;
            ctrl2_q <= ctrl2_d;
        end
    end

    assign o_ready = ~stall;
    assign o_done  = v3_q;

    for (genvar k = 0; k < int'(LANES); k++) begin : g_lane
        gf251_lane u_lane (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_stall    (stall),
            .i_x        (i_x[8*k +: 8]),
            .i_y        (i_y[8*k +: 8]),
            .i_s2_valid (v2_q),
            .i_s2_mac   (ctrl2_q.mode == ModeMac),
            .i_s2_clr   (ctrl2_q.clr),
            .o_res      (o_o[8*k +: 8])
        );
    end

endmodule

// File: tb/tb_gf251_mul_vec.sv
// Directed-vector bench for gf251_mul_vec: table stream, stall, reset, lane-count variants
// and a random phase against a mod-251 reference model.
module tb_gf251_mul_vec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] x = '0, y = '0;
    logic        mode = 1'b0, clr = 1'b0, start = 1'b0, rdy = 1'b1;
    logic        o_ready, o_done;
    logic [31:0] o_o;

    logic [7:0]  x1 = '0, y1 = '0, o1;
    logic        start1 = 1'b0, ready1, done1;
    logic [63:0] x8 = '0, y8 = '0, o8;
    logic        start8 = 1'b0, ready8, done8;

    always #5 clk = ~clk;

    gf251_mul_vec #(.LANES(4)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_x(x), .i_y(y), .i_mode(mode), .i_acc_clr(clr),
        .i_start(start), .o_ready(o_ready), .o_o(o_o), .o_done(o_done), .i_ready(rdy)
    );

    gf251_mul_vec #(.LANES(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_x(x1), .i_y(y1), .i_mode(1'b0), .i_acc_clr(1'b0),
        .i_start(start1), .o_ready(ready1), .o_o(o1), .o_done(done1), .i_ready(1'b1)
    );

    gf251_mul_vec #(.LANES(8)) u_dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_x(x8), .i_y(y8), .i_mode(1'b0), .i_acc_clr(1'b0),
        .i_start(start8), .o_ready(ready8), .o_o(o8), .o_done(done8), .i_ready(1'b1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [31:0] out_q[$];
    int          out_cyc[$];
    int          acc_cyc[$];
    logic [31:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_done && rdy) begin
            out_q.push_back(o_o);
            out_cyc.push_back(cyc);
        end
        if (start && o_ready && rst_n) acc_cyc.push_back(cyc);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Call only at posedge+#1; returns at posedge+#1 after the beat is accepted.
    task automatic send(input logic [31:0] bx, input logic [31:0] by, input logic bm,
                        input logic bc);
        bit ok;
        ok = 1'b0;
        x = bx; y = by; mode = bm; clr = bc; start = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (o_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("send_accept", 64'(ok), 64'd1);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_out(input int n, input string name);
        for (int k = 0; k < 200 && out_q.size() < n; k++) @(negedge clk);
        chk(name, 64'(out_q.size()), 64'(n));
    endtask

    task automatic clear_q();
        out_q.delete();
        out_cyc.delete();
        acc_cyc.delete();
        exp_q.delete();
    endtask

    typedef struct {
        string       name;
        logic [31:0] x;
        logic [31:0] y;
        logic        mode;
        logic        clr;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[11];

    logic [7:0] acc_m[4];

    initial begin
        tbl[0]  = '{"t1_mul",     32'h22222222, 32'h44444444, 1'b0, 1'b0, 32'h35353535};
        tbl[1]  = '{"t2_ff",      32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h10101010};
        tbl[2]  = '{"t2_mix",     32'h12345678, 32'h87654321, 1'b0, 1'b0, 32'hABE8F0C3};
        tbl[3]  = '{"t3_mac_clr", 32'h02020202, 32'h7E7E7E7E, 1'b1, 1'b1, 32'h01010101};
        tbl[4]  = '{"t3_mac2",    32'h02020202, 32'h7E7E7E7E, 1'b1, 1'b0, 32'h02020202};
        tbl[5]  = '{"t3_mac3",    32'h02020202, 32'h7E7E7E7E, 1'b1, 1'b0, 32'h03030303};
        tbl[6]  = '{"mul_clr_ign",32'h22222222, 32'h44444444, 1'b0, 1'b1, 32'h35353535};
        tbl[7]  = '{"mac_after",  32'h02020202, 32'h7E7E7E7E, 1'b1, 1'b0, 32'h04040404};
        tbl[8]  = '{"mac_lanes",  32'h01020304, 32'h05060708, 1'b1, 1'b0, 32'h09101924};
        tbl[9]  = '{"mac_fold",   32'hFBFCFDFE, 32'hFAFAFAFA, 1'b1, 1'b1, 32'h00FAF9F8};
        tbl[10] = '{"mac_wrap",   32'h01010101, 32'h02020202, 1'b1, 1'b0, 32'h020100FA};

        // Reset state
        #12;
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_oo", 64'(o_o), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // LANES=1 and LANES=8 variants: 0xFA * 0xFA = 1 (mod 251)
        x1 = 8'hFA; y1 = 8'hFA; start1 = 1'b1;
        x8 = {8{8'hFA}}; y8 = {8{8'hFA}}; start8 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0; start8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("l1_early", 64'(done1), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("l1_done", 64'(done1), 64'd1);
        chk("l1_oo", 64'(o1), 64'h01);
        chk("l8_done", 64'(done8), 64'd1);
        chk("l8_oo", o8, 64'h0101010101010101);
        @(posedge clk);
        #1;

        // Table stream, back-to-back
        clear_q();
        foreach (tbl[i]) send(tbl[i].x, tbl[i].y, tbl[i].mode, tbl[i].clr);
        wait_out(11, "tbl_count");
        foreach (tbl[i]) begin
            if (i < out_q.size() && i < acc_cyc.size()) begin
                chk(tbl[i].name, 64'(out_q[i]), 64'(tbl[i].exp));
                chk({tbl[i].name, "_lat"}, 64'(out_cyc[i] - acc_cyc[i]), 64'd3);
            end
        end
        repeat (3) @(posedge clk);
        #1;

        // Stall with three beats in flight
        clear_q();
        rdy = 1'b0;
        fork
            begin
                send(32'h01010101, 32'h02020202, 1'b0, 1'b0);
                send(32'h02020202, 32'h02020202, 1'b0, 1'b0);
                send(32'h03030303, 32'h02020202, 1'b0, 1'b0);
                send(32'h04040404, 32'h02020202, 1'b0, 1'b0);
            end
            begin
                int k;
                k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (!o_done && k < 20);
                for (int j = 0; j < 4; j++) begin
                    if (j > 0) @(negedge clk);
                    chk("stall_done", 64'(o_done), 64'd1);
                    chk("stall_oo", 64'(o_o), 64'h02020202);
                    chk("stall_ready", 64'(o_ready), 64'd0);
                end
                @(posedge clk);
                #1 rdy = 1'b1;
            end
        join
        wait_out(4, "stall_count");
        repeat (4) @(negedge clk);
        chk("stall_nodup", 64'(out_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < out_q.size(); i++)
            chk($sformatf("stall_ord%0d", i), 64'(out_q[i]), 64'(32'h02020202 * (i + 1)));
        @(posedge clk);
        #1;

        // Reset with two MAC beats in flight
        send(32'h02020202, 32'h7E7E7E7E, 1'b1, 1'b0);
        send(32'h02020202, 32'h7E7E7E7E, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_done", 64'(o_done), 64'd0);
        chk("mid_rst_oo", 64'(o_o), 64'd0);
        chk("mid_rst_ready", 64'(o_ready), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_q();
        begin
            int rel_cyc;
            rel_cyc = cyc;
            send(32'h02020202, 32'h7E7E7E7E, 1'b1, 1'b0);
            if (acc_cyc.size() > 0) chk("post_rst_accept", 64'(acc_cyc[0]), 64'(rel_cyc));
        end
        wait_out(1, "post_rst_count");
        repeat (4) @(negedge clk);
        chk("post_rst_nostray", 64'(out_q.size()), 64'd1);
        if (out_q.size() > 0) chk("post_rst_acc0", 64'(out_q[0]), 64'h01010101);
        @(posedge clk);
        #1;

        // Random beats with random backpressure against a reference model
        clear_q();
        foreach (acc_m[k]) acc_m[k] = 8'd0;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    logic [31:0] xr, yr, e;
                    logic        md, cl;
                    xr = $urandom;
                    yr = $urandom;
                    md = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                    cl = (i == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
                    for (int k = 0; k < 4; k++) begin
                        int a, b, p;
                        a = int'(xr[8*k +: 8]) % 251;
                        b = int'(yr[8*k +: 8]) % 251;
                        p = (a * b) % 251;
                        if (md) begin
                            acc_m[k] = cl ? 8'(p) : 8'((int'(acc_m[k]) + p) % 251);
                            e[8*k +: 8] = acc_m[k];
                        end else begin
                            e[8*k +: 8] = 8'(p);
                        end
                    end
                    exp_q.push_back(e);
                    send(xr, yr, md, cl);
                end
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    @(posedge clk);
                    #1 rdy = 1'($urandom_range(0, 1));
                end
                @(posedge clk);
                #1 rdy = 1'b1;
            end
        join
        wait_out(24, "rand_count");
        for (int i = 0; i < 24 && i < out_q.size(); i++)
            chk($sformatf("rand%0d", i), 64'(out_q[i]), 64'(exp_q[i]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
